// File: rtl/acl_sample_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acl_sample_filter_pkg
// Purpose  : Shared widths, field offsets and FSM state encoding for the
//            accelerometer sample filter.
//            Word packing: X[14:10] Y[9:5] Z[4:0], each field 5-bit signed.
// Revision : 1.0 - initial release
// ============================================================================
package acl_sample_filter_pkg;

    localparam int AXIS_W   = 5;
    localparam int ACL_W    = 15;
    localparam int NUM_AXES = 3;

    localparam int X_LSB = 10;
    localparam int Y_LSB = 5;
    localparam int Z_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // Axis index -> LSB position inside the packed word (0 = X, 1 = Y, 2 = Z).
    function automatic int axis_lsb(input int idx);
        case (idx)
            0:       return X_LSB;
            1:       return Y_LSB;
            default: return Z_LSB;
        endcase
    endfunction

endpackage : acl_sample_filter_pkg
`default_nettype wire

// File: rtl/acl_axis_avg.sv
`default_nettype none
// ============================================================================
// Module   : acl_axis_avg
// Purpose  : Moving average of one signed axis over 2**LOG2_DEPTH samples,
//            kept as a circular buffer plus a running sum.
// Ports    : clk_i   in   clock
//            rst_ni  in   asynchronous active-low reset
//            en_i    in   accept din_i into the window this cycle
//            din_i   in   AXIS_W-bit two's complement sample
//            avg_o   out  floor(window sum / depth), AXIS_W bits
// Revision : 1.0 - initial release
// ============================================================================
module acl_axis_avg #(
    parameter int AXIS_W     = 5,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [AXIS_W-1:0] din_i,
    output logic [AXIS_W-1:0] avg_o
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = AXIS_W + LOG2_DEPTH;

    logic [AXIS_W-1:0]       buf_q [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr_q;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sum_d;
    logic [AXIS_W-1:0]       w_old;
    logic signed [SUM_W-1:0] w_din_ext;
    logic signed [SUM_W-1:0] w_old_ext;

    assign w_old     = buf_q[wr_ptr_q];
    assign w_din_ext = {{LOG2_DEPTH{din_i[AXIS_W-1]}}, din_i};
    assign w_old_ext = {{LOG2_DEPTH{w_old[AXIS_W-1]}}, w_old};

    // The sum holds exactly the window contents, so it never overflows SUM_W.
    always_comb begin
        sum_d = sum_q;
        if (en_i) begin
            sum_d = sum_q + w_din_ext - w_old_ext;
        end
    end

    // avg_o is taken from the next-state sum so that, in the cycle en_i is
    // high, it already reflects the window including the incoming sample.
    // An arithmetic shift by LOG2_DEPTH truncated to AXIS_W bits is exactly
    // the top AXIS_W bits of the sum.
    assign avg_o = sum_d[LOG2_DEPTH +: AXIS_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else begin
            sum_q <= sum_d;
            if (en_i) begin
                buf_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + LOG2_DEPTH'(1);
            end
        end
    end

endmodule : acl_axis_avg
`default_nettype wire

// File: rtl/acl_sample_filter.sv
`default_nettype none
// ============================================================================
// Module   : acl_sample_filter
// Purpose  : Brings the packed X/Y/Z accelerometer word into the system clock
//            domain, samples it at a fixed rate once it has been stable for
//            STABLE_CYCLES cycles, averages each axis over 2**LOG2_DEPTH
//            samples and publishes the result with a one-cycle strobe.
// Ports    : CLK100MHZ    in   system clock
//            rst_n        in   asynchronous active-low reset
//            acl_data_in  in   raw word from SPI master (other clock domain)
//            filt_data    out  filtered word, same packing
//            filt_valid   out  one-cycle pulse when filt_data updates
//            filt_primed  out  window fully populated since reset
// Revision : 1.0 - initial release
// ============================================================================
import acl_sample_filter_pkg::*;

module acl_sample_filter #(
    parameter int SAMPLE_DIV    = 1_000_000,
    parameter int STABLE_CYCLES = 8,
    parameter int LOG2_DEPTH    = 3
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic [ACL_W-1:0] acl_data_in,
    output logic [ACL_W-1:0] filt_data,
    output logic             filt_valid,
    output logic             filt_primed
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int TMR_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int FILL_W = LOG2_DEPTH + 1;

    logic [ACL_W-1:0]  meta_q;
    logic [ACL_W-1:0]  sync_q;
    logic [TMR_W-1:0]  timer_q;
    logic              w_tick;
    state_t            state_q;
    state_t            state_d;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [STAB_W-1:0] stab_cnt_d;
    logic [ACL_W-1:0]  cand_q;
    logic [ACL_W-1:0]  cand_d;
    logic [FILL_W-1:0] fill_cnt_q;
    logic [FILL_W-1:0] fill_cnt_d;
    logic              w_update;
    logic [ACL_W-1:0]  w_avg_word;
    logic [ACL_W-1:0]  filt_data_q;
    logic              filt_valid_q;
    logic              filt_primed_q;

    // Synchronizer and free-running sample timer. Bits of the word may
    // arrive skewed; only the stability check below guards against that.
    assign w_tick = (timer_q == TMR_W'(SAMPLE_DIV - 1));

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            timer_q <= '0;
        end else begin
            meta_q  <= acl_data_in;
            sync_q  <= meta_q;
            timer_q <= w_tick ? '0 : timer_q + TMR_W'(1);
        end
    end

    // Sampling FSM
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        cand_d     = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    state_d    = ST_SETTLE;
                    stab_cnt_d = '0;
                    cand_d     = sync_q;
                end
            end
            ST_SETTLE: begin
                // A new tick before the word settles restarts the attempt
                // rather than queuing a second one, so each period yields at
                // most one accepted sample.
                if (w_tick) begin
                    cand_d     = sync_q;
                    stab_cnt_d = '0;
                end else if (sync_q == cand_q) begin
                    if (stab_cnt_q == STAB_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_UPDATE;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_W'(1);
                    end
                end else begin
                    cand_d     = sync_q;
                    stab_cnt_d = '0;
                end
            end
            ST_UPDATE:  state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stab_cnt_q <= '0;
            cand_q     <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            cand_q     <= cand_d;
        end
    end

    assign w_update = (state_q == ST_UPDATE);

    // Per-axis averagers; cand_q holds the accepted word during UPDATE.
    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        localparam int LSB = axis_lsb(g);
        acl_axis_avg #(
            .AXIS_W     (AXIS_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_avg (
            .clk_i  (CLK100MHZ),
            .rst_ni (rst_n),
            .en_i   (w_update),
            .din_i  (cand_q[LSB +: AXIS_W]),
            .avg_o  (w_avg_word[LSB +: AXIS_W])
        );
    end

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (w_update && (fill_cnt_q != FILL_W'(DEPTH))) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end
    end

    // Outputs are registered on the UPDATE->PUBLISH edge, so the strobe,
    // data and primed flag are all visible together during PUBLISH.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q    <= '0;
            filt_data_q   <= '0;
            filt_valid_q  <= 1'b0;
            filt_primed_q <= 1'b0;
        end else begin
            fill_cnt_q   <= fill_cnt_d;
            filt_valid_q <= w_update;
            if (w_update) begin
                filt_data_q <= w_avg_word;
                if (fill_cnt_d == FILL_W'(DEPTH)) begin
                    filt_primed_q <= 1'b1;
                end
            end
        end
    end

    assign filt_data   = filt_data_q;
    assign filt_valid  = filt_valid_q;
    assign filt_primed = filt_primed_q;

endmodule : acl_sample_filter
`default_nettype wire
